// File: rtl/conf_stream_pkg.sv
// conf_stream_pkg
// Shared definitions for the configuration stream writer:
//   - state_t     : frame parser states
//   - B_*         : byte index of each field inside a frame
//   - TILE_ID_W   : width of the tile id byte
package conf_stream_pkg;

  localparam int TILE_ID_W = 8;

  // Byte positions of the frame fields. Data starts at B_DATA and runs for
  // len+1 bytes. The optional checksum byte follows the last data byte.
  localparam int B_TILE = 0;
  localparam int B_AHI  = 1;
  localparam int B_ALO  = 2;
  localparam int B_LEN  = 3;
  localparam int B_DATA = 4;

  typedef enum logic [2:0] {
    S_TILE = 3'd0,
    S_AHI  = 3'd1,
    S_ALO  = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_CHK  = 3'd5
  } state_t;

endpackage

// File: rtl/conf_onehot_dec.sv
// conf_onehot_dec
// Decodes an 8-bit tile id into a NB_TILES-wide one-hot select vector.
// Ports:
//   tile_id      in  TILE_ID_W  tile number from the frame header
//   onehot       out NB_TILES   one bit set for an in-range id, all zero otherwise
//   out_of_range out 1          tile_id >= NB_TILES
module conf_onehot_dec
  import conf_stream_pkg::*;
#(
  parameter int NB_TILES = 16
) (
  input  logic [TILE_ID_W-1:0] tile_id,
  output logic [NB_TILES-1:0]  onehot,
  output logic                 out_of_range
);

  // An out-of-range id matches no bit position, so the vector is
  // naturally all zero in that case.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NB_TILES; i++) begin
      onehot[i] = (tile_id == TILE_ID_W'(i));
    end
  end

  assign out_of_range = (int'(tile_id) >= NB_TILES);

endmodule

// File: rtl/conf_stream_writer.sv
// conf_stream_writer
// Parses a byte stream of framed configuration records and expands each
// record into single-cycle tile writes with an auto-incrementing address.
//
// Frame: tile id, addr high, addr low, len, then len+1 data bytes,
// followed by an XOR checksum byte when CONF_STREAM_WRITER_CHK_EN is defined.
//
// Ports:
//   conf          in   clock, all logic on the rising edge
//   reset         in   synchronous active-high reset
//   in_data       in   stream byte
//   in_valid      in   in_data valid
//   in_ready      out  byte accepted when in_valid && in_ready
//   clear_err     in   clears the sticky error flags
//   select_tile   out  one-hot write strobe, one bit per tile
//   address_tile  out  write address
//   data_tile     out  write data
//   busy          out  a frame is in progress
//   frame_done    out  one-cycle pulse after the last frame byte
//   err_tile      out  sticky, tile id >= NB_TILES seen
//   err_chk       out  sticky, checksum mismatch (0 without the macro)
//
// Optional feature macro: CONF_STREAM_WRITER_CHK_EN
// ADDR_W must lie in 9..16 (upper address bits come from byte B1).
module conf_stream_writer
  import conf_stream_pkg::*;
#(
  parameter int NB_TILES = 16,
  parameter int ADDR_W   = 10
) (
  input  logic                conf,
  input  logic                reset,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                clear_err,
  output logic [NB_TILES-1:0] select_tile,
  output logic [ADDR_W-1:0]   address_tile,
  output logic [7:0]          data_tile,
  output logic                busy,
  output logic                frame_done,
  output logic                err_tile,
  output logic                err_chk
);

  state_t              state_q;
  logic                in_ready_q;
  logic [NB_TILES-1:0] tile_sel_q;
  logic                discard_q;
  logic [ADDR_W-9:0]   addr_hi_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          cnt_q;
  logic [NB_TILES-1:0] select_q;
  logic [ADDR_W-1:0]   address_q;
  logic [7:0]          data_q;
  logic                frame_done_q;
  logic                err_tile_q;

  logic                accept;
  logic [NB_TILES-1:0] dec_onehot;
  logic                dec_oor;

  assign accept = in_valid && in_ready_q;

  // Decoding is done straight off the incoming byte so the one-hot
  // vector is ready to latch in the same cycle B0 is accepted.
  conf_onehot_dec #(
    .NB_TILES(NB_TILES)
  ) u_dec (
    .tile_id     (in_data),
    .onehot      (dec_onehot),
    .out_of_range(dec_oor)
  );

  // Frame parser and write issue. The strobe defaults to zero each cycle
  // so a write lasts exactly one cycle; address and data hold their last
  // value between writes. Error set is ordered after clear so set wins.
  always_ff @(posedge conf) begin
    if (reset) begin
      state_q      <= S_TILE;
      in_ready_q   <= 1'b0;
      tile_sel_q   <= '0;
      discard_q    <= 1'b0;
      addr_hi_q    <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      select_q     <= '0;
      address_q    <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      err_tile_q   <= 1'b0;
    end else begin
      in_ready_q   <= 1'b1;
      select_q     <= '0;
      frame_done_q <= 1'b0;
      if (clear_err) begin
        err_tile_q <= 1'b0;
      end
      if (accept) begin
        case (state_q)
          S_TILE: begin
            tile_sel_q <= dec_onehot;
            discard_q  <= dec_oor;
            if (dec_oor) begin
              err_tile_q <= 1'b1;
            end
            state_q <= S_AHI;
          end
          S_AHI: begin
            addr_hi_q <= in_data[ADDR_W-9:0];
            state_q   <= S_ALO;
          end
          S_ALO: begin
            addr_q  <= {addr_hi_q, in_data};
            state_q <= S_LEN;
          end
          S_LEN: begin
            cnt_q   <= in_data;
            state_q <= S_DATA;
          end
          S_DATA: begin
            select_q  <= discard_q ? '0 : tile_sel_q;
            address_q <= addr_q;
            data_q    <= in_data;
            addr_q    <= addr_q + ADDR_W'(1);
            if (cnt_q == 8'd0) begin
`ifdef CONF_STREAM_WRITER_CHK_EN
              state_q <= S_CHK;
`else
              state_q      <= S_TILE;
              frame_done_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
`ifdef CONF_STREAM_WRITER_CHK_EN
          S_CHK: begin
            state_q      <= S_TILE;
            frame_done_q <= 1'b1;
          end
`endif
          default: begin
            state_q <= S_TILE;
          end
        endcase
      end
    end
  end

`ifdef CONF_STREAM_WRITER_CHK_EN
  logic [7:0] chk_q;
  logic       err_chk_q;

  // Running XOR over B0..Dlen, restarted by B0. The comparison is only
  // advisory: the data has already been written by the time it arrives.
  always_ff @(posedge conf) begin
    if (reset) begin
      chk_q     <= '0;
      err_chk_q <= 1'b0;
    end else begin
      if (clear_err) begin
        err_chk_q <= 1'b0;
      end
      if (accept) begin
        case (state_q)
          S_TILE:  chk_q <= in_data;
          S_CHK: begin
            if (in_data != chk_q) begin
              err_chk_q <= 1'b1;
            end
          end
          default: chk_q <= chk_q ^ in_data;
        endcase
      end
    end
  end

  assign err_chk = err_chk_q;
`else
  assign err_chk = 1'b0;
`endif

  assign in_ready     = in_ready_q;
  assign select_tile  = select_q;
  assign address_tile = address_q;
  assign data_tile    = data_q;
  assign frame_done   = frame_done_q;
  assign err_tile     = err_tile_q;
  assign busy         = (state_q != S_TILE);

endmodule

// File: tb/tb_conf_stream_writer.sv
// tb_conf_stream_writer
// Scoreboard bench for conf_stream_writer: expected writes are queued as
// data bytes are driven and compared when the strobe appears.
// Honours CONF_STREAM_WRITER_CHK_EN to append checksum bytes.
module tb_conf_stream_writer;

  localparam int NB_TILES = 16;
  localparam int ADDR_W   = 10;

  logic                conf = 1'b0;
  logic                reset;
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic                clear_err;
  logic [NB_TILES-1:0] select_tile;
  logic [ADDR_W-1:0]   address_tile;
  logic [7:0]          data_tile;
  logic                busy;
  logic                frame_done;
  logic                err_tile;
  logic                err_chk;

  typedef struct packed {
    logic [NB_TILES-1:0] sel;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          data;
  } wr_t;

  wr_t exp_q[$];
  int  strobe_cyc[$];
  int  cycle = 0;
  int  n_compared = 0;
  int  n_mismatch = 0;
  int  done_seen = 0;
  int  done_exp = 0;

  conf_stream_writer #(
    .NB_TILES(NB_TILES),
    .ADDR_W  (ADDR_W)
  ) dut (
    .conf        (conf),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .clear_err   (clear_err),
    .select_tile (select_tile),
    .address_tile(address_tile),
    .data_tile   (data_tile),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_tile    (err_tile),
    .err_chk     (err_chk)
  );

  always #5 conf = ~conf;

  always @(posedge conf) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Strobe monitor: every nonzero select_tile must match the oldest
  // queued write; a strobe with nothing queued is an extra write.
  always @(negedge conf) begin
    wr_t e;
    if (frame_done === 1'b1) done_seen++;
    if (select_tile !== '0) begin
      strobe_cyc.push_back(cycle);
      if (exp_q.size() == 0) begin
        checkOutput("extra_strobe", 32'(select_tile), 32'h0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_sel", 32'(select_tile), 32'(e.sel));
        checkOutput("wr_addr", 32'(address_tile), 32'(e.addr));
        checkOutput("wr_data", 32'(data_tile), 32'(e.data));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idleCycles(input int n);
    repeat (n) @(negedge conf);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic sendByte(input logic [7:0] b);
    int w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      in_valid = 1'b0;
      @(negedge conf);
      w++;
    end
    if (in_ready !== 1'b1) checkOutput("ready_timeout", 32'(in_ready), 32'h1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge conf);
    in_valid = 1'b0;
  endtask

  // Drives a frame (optionally truncated, optionally with random gaps) and
  // queues the writes the frame should produce.
  task automatic applyStimulus(input logic [7:0] fr[$], input int gap_pct,
                               input bit partial, input bit bad_chk);
    logic [7:0]        tile;
    logic [ADDR_W-1:0] base;
    logic [7:0]        chk;
    logic [7:0]        hi;
    wr_t               w;
    tile = fr[0];
    hi   = fr[1];
    base = {hi[1:0], fr[2]};
    chk  = 8'h00;
    for (int i = 0; i < fr.size(); i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idleCycles($urandom_range(1, 3));
      if (i >= 4 && int'(tile) < NB_TILES) begin
        w.sel  = NB_TILES'(1) << tile;
        w.addr = base + ADDR_W'(i - 4);
        w.data = fr[i];
        exp_q.push_back(w);
      end
      chk = chk ^ fr[i];
      sendByte(fr[i]);
      if (i == 0) checkOutput("busy_mid", 32'(busy), 32'h1);
    end
    if (!partial) begin
`ifdef CONF_STREAM_WRITER_CHK_EN
      sendByte(bad_chk ? (chk ^ 8'h5A) : chk);
`endif
      done_exp++;
    end
  endtask

  initial begin
    logic [7:0] fr[$];
    int base;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    clear_err = 1'b0;
    idleCycles(3);
    checkOutput("rst_select", 32'(select_tile), 32'h0);
    checkOutput("rst_ready", 32'(in_ready), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_err_tile", 32'(err_tile), 32'h0);
    reset = 1'b0;
    idleCycles(1);

    $display("[TB] single write");
    fr = '{8'h03, 8'h00, 8'h10, 8'h00, 8'hA5};
    applyStimulus(fr, 0, 1'b0, 1'b0);
    idleCycles(3);
    checkOutput("single_done", 32'(done_seen), 32'(done_exp));
    checkOutput("single_idle_busy", 32'(busy), 32'h0);
    checkOutput("single_err_chk", 32'(err_chk), 32'h0);

    $display("[TB] burst with address wrap");
    base = strobe_cyc.size();
    fr = '{8'h01, 8'h03, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(fr, 0, 1'b0, 1'b0);
    idleCycles(3);
    checkOutput("burst_count", 32'(strobe_cyc.size() - base), 32'h4);
    if (strobe_cyc.size() - base >= 4)
      checkOutput("burst_consecutive", 32'(strobe_cyc[base+3] - strobe_cyc[base]), 32'h3);
    checkOutput("burst_done", 32'(done_seen), 32'(done_exp));

    $display("[TB] burst with random valid gaps");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(fr, 40, 1'b0, 1'b0);
      idleCycles($urandom_range(0, 2));
    end
    idleCycles(3);
    checkOutput("gap_done", 32'(done_seen), 32'(done_exp));

    $display("[TB] out-of-range tile");
    fr = '{8'h20, 8'h00, 8'h00, 8'h01, 8'h55, 8'h66};
    applyStimulus(fr, 0, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("oor_err_tile", 32'(err_tile), 32'h1);
    checkOutput("oor_done", 32'(done_seen), 32'(done_exp));
    fr = '{8'h0F, 8'h02, 8'h20, 8'h01, 8'hAA, 8'hBB};
    applyStimulus(fr, 0, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("oor_err_sticky", 32'(err_tile), 32'h1);
    clear_err = 1'b1;
    idleCycles(1);
    clear_err = 1'b0;
    idleCycles(1);
    checkOutput("oor_err_cleared", 32'(err_tile), 32'h0);

    $display("[TB] reset mid-frame");
    fr = '{8'h04, 8'h00, 8'h40, 8'h03, 8'hC1, 8'hC2};
    applyStimulus(fr, 0, 1'b1, 1'b0);
    reset = 1'b1;
    idleCycles(1);
    checkOutput("mid_rst_select", 32'(select_tile), 32'h0);
    checkOutput("mid_rst_addr", 32'(address_tile), 32'h0);
    checkOutput("mid_rst_data", 32'(data_tile), 32'h0);
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'h0);
    checkOutput("mid_rst_done", 32'(frame_done), 32'h0);
    idleCycles(1);
    reset = 1'b0;
    idleCycles(1);
    fr = '{8'h00, 8'h00, 8'h05, 8'h00, 8'h77};
    applyStimulus(fr, 0, 1'b0, 1'b0);
    idleCycles(3);
    checkOutput("post_rst_done", 32'(done_seen), 32'(done_exp));

`ifdef CONF_STREAM_WRITER_CHK_EN
    $display("[TB] checksum");
    fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h0F};
    applyStimulus(fr, 0, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("chk_good", 32'(err_chk), 32'h0);
    applyStimulus(fr, 0, 1'b0, 1'b1);
    idleCycles(2);
    checkOutput("chk_bad", 32'(err_chk), 32'h1);
    clear_err = 1'b1;
    idleCycles(1);
    clear_err = 1'b0;
    idleCycles(1);
    checkOutput("chk_cleared", 32'(err_chk), 32'h0);
`else
    checkOutput("chk_tied_low", 32'(err_chk), 32'h0);
`endif

    idleCycles(5);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
    checkOutput("total_done", 32'(done_seen), 32'(done_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
